fetch_unit: RTL and testbench

Instruction fetch stage of the three-stage RISC-V core. It owns the program counter and drives the synchronous instruction memory (1-cycle read latency). It presents `inst_fd` / `pc_fd` / `valid_fd` to the fetch/decode control logic and immediate generator. It accepts stall and redirect (branch/jump) requests from later stages and inserts NOP bubbles on reset, flush and startup.

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Owns the PC, drives a synchronous
//             (1-cycle latency) instruction memory and presents the fetched
//             instruction to decode. Handles stall, redirect and NOP bubbles.
//  Option   : FETCH_MISALIGN_FIX_EN - when defined, redirect targets are
//             forced to word alignment before use.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                 W_SIZE   = 32,
  parameter logic [W_SIZE-1:0]  RESET_PC = 32'h4000_0000,
  parameter logic [W_SIZE-1:0]  NOP      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [W_SIZE-1:0] redirect_pc,
  output logic [W_SIZE-1:0] imem_addr,
  input  logic [W_SIZE-1:0] imem_rdata,
  output logic [W_SIZE-1:0] inst_fd,
  output logic [W_SIZE-1:0] pc_fd,
  output logic              valid_fd,
  output logic [W_SIZE-1:0] fetch_count
);

  // Address held in the slot after reset; +4 of it is the first real fetch.
  localparam logic [W_SIZE-1:0] c_pc_rst_prev = RESET_PC - W_SIZE'(4);

  logic [W_SIZE-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [W_SIZE-1:0] cnt_q, cnt_d;
  logic [W_SIZE-1:0] redirect_tgt;
  logic [W_SIZE-1:0] pc_sel;
  logic              live;

`ifdef FETCH_MISALIGN_FIX_EN
  // Word-align the redirect target so the PC can never go misaligned.
  assign redirect_tgt = redirect_pc & ~W_SIZE'(3);
`else
  // Misaligned targets pass through; execute is responsible for trapping.
  assign redirect_tgt = redirect_pc;
`endif

  // Next-address select, next-state values and decode-facing outputs.
  always_comb begin
    pc_sel  = pc_q + W_SIZE'(4);
    valid_d = 1'b1;
    if (redirect_valid) begin
      pc_sel  = redirect_tgt;
      valid_d = 1'b1;
    end else if (stall) begin
      pc_sel  = pc_q;
      valid_d = valid_q;
    end
    pc_d  = pc_sel;

    // A redirect kills whatever currently sits in the F/D slot.
    live  = valid_q & ~redirect_valid;
    cnt_d = cnt_q;
    if (live && !stall) begin
      cnt_d = cnt_q + W_SIZE'(1);
    end
  end

  assign imem_addr   = rst ? c_pc_rst_prev : pc_sel;
  assign inst_fd     = live ? imem_rdata : NOP;
  assign pc_fd       = pc_q;
  assign valid_fd    = live;
  assign fetch_count = cnt_q;

  // State register; reset discards any in-flight fetch and overrides stall/redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= c_pc_rst_prev;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: memory model, slot-level
//             reference model compared every cycle, plus directed literal
//             expectations. Honours FETCH_MISALIGN_FIX_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_fd, pc_fd, fetch_count;
  logic        valid_fd;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.W_SIZE(32), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_fd(inst_fd), .pc_fd(pc_fd), .valid_fd(valid_fd),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: an arbitrary address-dependent pattern.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Synchronous memory: data for the address presented appears next cycle.
  initial imem_rdata = '0;
  always @(posedge clk) imem_rdata <= mem_f(imem_addr);

  function automatic logic [31:0] align_f(input logic [31:0] a);
`ifdef FETCH_MISALIGN_FIX_EN
    return {a[31:2], 2'b00};
`else
    return a;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the F/D slot is the fetch whose data is on the bus now.
  logic [31:0] m_pc;
  logic        m_live;
  logic [31:0] m_cnt;
  logic        m_ready = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc    <= RESET_PC - 32'd4;
      m_live  <= 1'b0;
      m_cnt   <= 32'd0;
      m_ready <= 1'b1;
    end else begin
      if (m_live && !redirect_valid && !stall) m_cnt <= m_cnt + 32'd1;
      if (redirect_valid) begin
        m_pc <= align_f(redirect_pc); m_live <= 1'b1;
      end else if (!stall) begin
        m_pc <= m_pc + 32'd4;         m_live <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (m_ready) begin
      logic        e_valid;
      logic [31:0] e_addr;
      e_valid = m_live && !redirect_valid;
      e_addr  = redirect_valid ? align_f(redirect_pc) : (stall ? m_pc : m_pc + 32'd4);
      chk("model valid_fd", {31'd0, valid_fd}, {31'd0, e_valid});
      chk("model pc_fd", pc_fd, m_pc);
      chk("model inst_fd", inst_fd, e_valid ? mem_f(m_pc) : NOP);
      chk("model fetch_count", fetch_count, m_cnt);
      if (!rst) chk("model imem_addr", imem_addr, e_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " valid_fd"}, {31'd0, valid_fd}, 32'd0);
    chk({tag, " inst_fd"}, inst_fd, NOP);
    chk({tag, " pc_fd"}, pc_fd, 32'h3FFF_FFFC);
    chk({tag, " fetch_count"}, fetch_count, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset and startup
    tick(); tick(); tick();
    settle();
    chk_reset_vals("reset");
    rst = 1'b0; settle();                                    // cycle 1
    chk("start c1 valid_fd", {31'd0, valid_fd}, 32'd0);
    tick();                                                  // cycle 2
    chk("start c2 pc_fd", pc_fd, 32'h4000_0000);
    chk("start c2 inst_fd", inst_fd, mem_f(32'h4000_0000));
    chk("start c2 valid_fd", {31'd0, valid_fd}, 32'd1);
    tick();                                                  // cycle 3
    chk("start c3 pc_fd", pc_fd, 32'h4000_0004);
    tick();                                                  // cycle 4
    chk("start c4 fetch_count", fetch_count, 32'd2);
    chk("start c4 pc_fd", pc_fd, 32'h4000_0008);

    // Stall three cycles at 4000_0008
    stall = 1'b1; settle();
    chk("stall imem_addr", imem_addr, 32'h4000_0008);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall pc_fd", pc_fd, 32'h4000_0008);
      chk("stall inst_fd", inst_fd, mem_f(32'h4000_0008));
      chk("stall imem_addr", imem_addr, 32'h4000_0008);
      chk("stall fetch_count", fetch_count, 32'd2);
    end
    tick(); stall = 1'b0; settle();
    chk("unstall pc_fd", pc_fd, 32'h4000_0008);
    tick();
    chk("after stall pc_fd", pc_fd, 32'h4000_000C);
    chk("after stall fetch_count", fetch_count, 32'd3);

    // Redirect
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0020; settle();
    chk("redir N valid_fd", {31'd0, valid_fd}, 32'd0);
    chk("redir N inst_fd", inst_fd, NOP);
    tick(); redirect_valid = 1'b0; settle();
    chk("redir N+1 pc_fd", pc_fd, 32'h1000_0020);
    chk("redir N+1 valid_fd", {31'd0, valid_fd}, 32'd1);
    chk("redir N+1 inst_fd", inst_fd, mem_f(32'h1000_0020));
    tick();
    chk("redir N+2 pc_fd", pc_fd, 32'h1000_0024);

    // Redirect together with stall
    redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h1000_0040;
    tick(); redirect_valid = 1'b0; stall = 1'b0; settle();
    chk("redir+stall pc_fd", pc_fd, 32'h1000_0040);
    chk("redir+stall valid_fd", {31'd0, valid_fd}, 32'd1);

    // Back-to-back redirects: only the last target is fetched
    redirect_valid = 1'b1; redirect_pc = 32'h2000_0100;
    tick(); redirect_pc = 32'h3000_0200;
    tick(); redirect_valid = 1'b0; settle();
    chk("b2b pc_fd", pc_fd, 32'h3000_0200);
    chk("b2b valid_fd", {31'd0, valid_fd}, 32'd1);

    // Address wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect_valid = 1'b0; settle();
    chk("wrap pc_fd 1", pc_fd, 32'hFFFF_FFFC);
    tick();
    chk("wrap pc_fd 2", pc_fd, 32'h0000_0000);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0022;
    tick(); redirect_valid = 1'b0; settle();
`ifdef FETCH_MISALIGN_FIX_EN
    chk("misalign pc_fd", pc_fd, 32'h1000_0020);
`else
    chk("misalign pc_fd", pc_fd, 32'h1000_0022);
`endif

    // Mixed stall pattern, checked by the model each cycle
    for (int i = 0; i < 12; i++) begin
      stall = ((i % 3) == 1);
      tick();
    end
    stall = 1'b0;

    // Reset mid-stream with stall and redirect high
    rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h5000_0000;
    tick(); rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; settle();
    chk_reset_vals("midreset");
    tick();
    chk("midreset live pc_fd", pc_fd, RESET_PC);
    chk("midreset live valid_fd", {31'd0, valid_fd}, 32'd1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
